// File: rtl/apb_initiator.sv
// apb_initiator
//   Converts a simple request/grant handshake into APB transfers.
//   The FSM walks through IDLE -> SETUP -> ACCESS. It reports completion with a
//   one-cycle rvalid_o pulse that carries the read data and the error flag.
//
// Optional feature (compile-time macro):
//   APB_INITIATOR_TIMEOUT_EN
//     Enables the ACCESS-phase watchdog. After TIMEOUT_CYCLES wait states the
//     transfer is abandoned and completes with err_o = 1.
//
// Parameters:
//   ADDR_WIDTH     APB address width
//   DATA_WIDTH     APB data width
//   TIMEOUT_CYCLES maximum ACCESS wait states, 1..65535 (timeout build only)
//
// Ports:
//   clk_i, rst_ni             rising-edge clock, asynchronous active-low reset
//   req_i, we_i               request valid, 1 = write / 0 = read
//   addr_i, wdata_i           request address and write data
//   gnt_o                     request accepted this cycle (combinational)
//   rvalid_o                  one-cycle completion pulse
//   rdata_o, err_o            read data and error flag, valid with rvalid_o
//   paddr_o, pwdata_o         APB address and write data
//   pwrite_o, psel_o          APB direction and select
//   penable_o                 APB enable
//   prdata_i                  APB read data
//   pready_i, pslverr_i       APB ready and slave error
module apb_initiator #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_grant;
  logic                    w_done;
  logic                    w_timeout;
  logic                    w_tmo_hit;

  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic                    r_pwrite;
  logic                    r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

`ifdef APB_INITIATOR_TIMEOUT_EN
  // The watchdog fires on the cycle where the count already covers
  // TIMEOUT_CYCLES-1 stalled cycles. That cycle is the TIMEOUT_CYCLES-th stall.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_grant) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ACCESS && !pready_i) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_grant     = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture and completion registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_paddr  <= addr_i;
        r_pwdata <= wdata_i;
        r_pwrite <= we_i;
      end
      r_rvalid <= w_done | w_timeout;
      if (w_done) begin
        // Writes return zero so stale read data never leaks into a write response.
        r_rdata <= r_pwrite ? '0 : prdata_i;
        r_err   <= pslverr_i;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  // The state resets asynchronously to IDLE, so psel/penable drop
  // without waiting for a clock edge. The grant is also masked while reset is held.
  assign gnt_o     = w_grant & rst_ni;
  assign psel_o    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable_o = (r_state == S_ACCESS);
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign pwrite_o  = r_pwrite;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;

endmodule
